fetch_unit: RTL

Instruction fetch stage of the single-cycle RISC-V core: owns the program counter, requests instruction words from instruction memory over a req/ack handshake, and holds the fetched word stable for the control decoder and datapath until the core retires it. On retire it advances the PC sequentially or redirects to a branch or jump target supplied by the execute logic. It sits directly upstream of `control`; its `instr` output drives the decoder's instruction input.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/fetch_unit.sv | 66 ++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants, opcodes and the fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [1:0] {FETCH, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over req/ack and holds the word until retire
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            instr_valid,
  input  logic            retire,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            fetch_err
);
  fetch_state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
  logic err_q, err_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      FETCH: if (imem_ack) begin
        instr_d = imem_rdata;
        state_d = HOLD;
      end
      HOLD: if (retire) begin
        pc_d    = branch_taken ? branch_target : pc_q + 32'd4;
        state_d = FETCH;
        // a misaligned redirect stops the core until reset
        if (branch_taken && branch_target[1:0] != 2'b00) begin
          err_d   = 1'b1;
          instr_d = NOP_INSTR;
          state_d = HALT;
        end
      end
      default: ;
    endcase
  end
  assign imem_req    = rst_n && state_q == FETCH;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = state_q == HOLD;
  assign fetch_err   = err_q;
endmodule
